ss_entrada_n: RTL and testbench
===============================

SS_ENTRADA_N -- requirements
Module: ss_entrada_n

Interface
REQ-001 Parameter WIDTH, 4, operand width in bits; legal range 2..16.
REQ-002 Parameter SYNC_STAGES, 2, number of boton synchroniser flops; legal range 2..3.
REQ-003 Parameter DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to change the debounced level; legal range 1..255.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 A  input  WIDTH  operand A from switches; asynchronous, stable when captured.
REQ-007 B  input  WIDTH  operand B from switches; asynchronous, stable when captured.
REQ-008 boton  input  1  raw push-button, asynchronous, bouncing, active-high.
REQ-009 ready  input  1  downstream multiplier accepts the current operand pair.
REQ-010 valid  output  1  registered; _A/_B hold a captured, unconsumed pair.
REQ-011 _A  output  WIDTH  registered captured A.
REQ-012 _B  output  WIDTH  registered captured B.
REQ-013 ovr  output  1  registered one-cycle pulse; a press was dropped.

Function
REQ-014 boton SHALL pass through a SYNC_STAGES-flop chain; its last stage is the synchronised signal s.
REQ-015 A debounce counter SHALL count cycles where s differs from the debounced level db, reset to 0 on any cycle s equals db, and toggle db on the edge where the count reaches DEBOUNCE_CYCLES.
REQ-016 A press event SHALL be the cycle db goes 0->1; releases and bounces shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-017 FSM SHALL have two states: IDLE (valid=0) and HOLD (valid=1).
REQ-018 IDLE + press: capture A,B into _A,_B, go to HOLD; valid SHALL be 1 from the same edge.
REQ-019 HOLD + ready + no press: go to IDLE; valid SHALL be 0 after that edge; _A/_B SHALL retain their value.
REQ-020 HOLD + no ready + press: stay in HOLD, keep _A/_B unchanged, pulse ovr for exactly one cycle.
REQ-021 HOLD + ready + press on the same edge: recapture A,B, stay in HOLD, valid stays 1, no ovr.
REQ-022 ready in IDLE SHALL be ignored.
REQ-023 Latency from boton held high (sampled at edge k) to valid=1 SHALL be SYNC_STAGES+DEBOUNCE_CYCLES edges (defaults: valid high after edge k+6).
REQ-024 Holding boton high indefinitely SHALL produce exactly one press event; the next event requires a debounced release.
REQ-025 A,B SHALL be captured unmodified at full WIDTH; no sign or zero extension.

Reset
REQ-026 rst=1 SHALL immediately clear synchroniser flops, counter, db, valid, ovr, _A and _B to 0 and force IDLE, regardless of clock.
REQ-027 Reset asserted mid-debounce or in HOLD SHALL discard the pending count and pair; after release a new full-latency press is required.
REQ-028 On rst deassertion with boton already high, a press SHALL be reported after the full latency of REQ-023.

Configuration
REQ-029 Macro SS_ENTRADA_DEBOUNCE_EN defined: debounce per REQ-015 is compiled in.
REQ-030 Macro not defined: counter is absent, db SHALL equal s delayed by one flop, latency SHALL be SYNC_STAGES+1 edges, DEBOUNCE_CYCLES ignored; all other behaviour unchanged.

Verification
REQ-031 Defaults, macro defined: A=4'b1011, B=4'b0110, boton 0->1 held -> valid=1 after 6th edge, _A=1011, _B=0110, ovr=0.
REQ-032 Bounce: boton 1 for 3 cycles, 0 for 1, 1 held -> no event until 4 stable synchronised samples; exactly one capture.
REQ-033 In HOLD, ready=0, release and re-press with A=4'b0001 -> ovr one-cycle pulse, _A stays 1011, valid stays 1.
REQ-034 In HOLD, ready=1 on the press-event edge with A=4'b0011 -> _A=0011, valid stays 1, ovr=0.
REQ-035 rst=1 asynchronously between clock edges while in HOLD -> valid, _A, _B, ovr read 0 before the next edge.
REQ-036 WIDTH=8, macro undefined, A=8'hA5, B=8'h3C, press -> valid after 3 edges, _A=A5, _B=3C; ready=1 -> valid=0 next edge.

Source files
------------

// File: rtl/ss_entrada_n.sv
// ss_entrada_n -- operand capture front-end for a switch-driven multiplier.
// A bouncing push-button is synchronised and debounced. Each clean press
// captures the switch operands A/B into _A/_B and raises valid until the
// downstream side consumes the pair with ready. A press that arrives while
// an unconsumed pair is pending is dropped and flagged with a one-cycle ovr.
// Optional feature: define SS_ENTRADA_DEBOUNCE_EN to build the debounce
// counter. Without it, db is just s delayed by one flop.
module ss_entrada_n #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             boton,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] _A,
  output logic [WIDTH-1:0] _B,
  output logic             ovr
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  // Stop elaboration on parameter values the datapath is not sized for.
  if (WIDTH < 2 || WIDTH > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_params
    $error("ss_entrada_n: parameter out of legal range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   db;
  logic                   db_d;
  logic                   press;
  state_t                 state;

  assign s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain that brings the raw button into the clk domain.
  // NOTE: every sequential block uses non-blocking assignments. Each flop then
  // samples the value its neighbour held before the edge, which is what makes
  // this a shift chain rather than a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], boton};
  end

`ifdef SS_ENTRADA_DEBOUNCE_EN
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [7:0] cnt;

  // Debounce: db flips only after DEBOUNCE_CYCLES consecutive samples of s
  // that disagree with it. Any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (s == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      db  <= ~db;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
`else
  // Without debounce: db is simply s delayed by one flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) db <= 1'b0;
    else     db <= s;
  end
`endif

  // Delayed copy of db. Its rising edge is the press event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) db_d <= 1'b0;
    else     db_d <= db;
  end

  assign press = db & ~db_d;

  // Handshake FSM. The outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      _A    <= '0;
      _B    <= '0;
      ovr   <= 1'b0;
    end else begin
      ovr <= 1'b0;
      case (state)
        IDLE: begin
          // ready is deliberately ignored while no pair is pending.
          if (press) begin
            _A    <= A;
            _B    <= B;
            state <= HOLD;
            valid <= 1'b1;
          end
        end
        HOLD: begin
          if (press && ready) begin
            // The pending pair is consumed on this edge, so the new press
            // can take its place without a gap in valid.
            _A <= A;
            _B <= B;
          end else if (press) begin
            ovr <= 1'b1;
          end else if (ready) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_entrada_n.sv
// tb_ss_entrada_n -- self-checking bench for ss_entrada_n.
// It runs a directed vector table, hand-written corner sequences and a
// randomized run. The randomized run is compared against a reference model
// that keeps the button history in queues. The model honours
// SS_ENTRADA_DEBOUNCE_EN in the same way the design does.
module tb_ss_entrada_n;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 4;
`ifdef SS_ENTRADA_DEBOUNCE_EN
  localparam int LAT = SS + DC;
`else
  localparam int LAT = SS + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0, b = '0;
  logic         boton = 1'b0, ready = 1'b0;
  logic         valid, ovr;
  logic [W-1:0] q_a, q_b;

  logic [7:0]   a8 = '0, b8 = '0;
  logic         boton8 = 1'b0, ready8 = 1'b0;
  logic         valid8, ovr8;
  logic [7:0]   q_a8, q_b8;

  ss_entrada_n #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) u_dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .boton(boton), .ready(ready),
    .valid(valid), ._A(q_a), ._B(q_b), .ovr(ovr)
  );

  ss_entrada_n #(.WIDTH(8), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .boton(boton8), .ready(ready8),
    .valid(valid8), ._A(q_a8), ._B(q_b8), .ovr(ovr8)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: button samples since reset, synchronised samples, db history.
  bit           bh[$];
  bit           sh[$];
  bit           dbh[$];
  logic         m_valid;
  logic [W-1:0] m_a, m_b;
  logic         m_ovr;

  function automatic void model_reset();
    bh.delete(); sh.delete(); dbh.delete();
    m_valid = 1'b0; m_a = '0; m_b = '0; m_ovr = 1'b0;
  endfunction

  // Called once per rising edge, using the inputs the design sampled there.
  function automatic void model_step();
    int n      = bh.size();
    bit s      = (n >= SS) ? bh[n-SS] : 1'b0;
    bit db_cur = (dbh.size() > 0) ? dbh[dbh.size()-1] : 1'b0;
    bit db_prv = (dbh.size() > 1) ? dbh[dbh.size()-2] : 1'b0;
    bit press  = db_cur && !db_prv;
    bit db_new = db_cur;
    m_ovr = 1'b0;
    if (!m_valid) begin
      if (press) begin m_a = a; m_b = b; m_valid = 1'b1; end
    end else if (press && ready) begin
      m_a = a; m_b = b;
    end else if (press) begin
      m_ovr = 1'b1;
    end else if (ready) begin
      m_valid = 1'b0;
    end
`ifdef SS_ENTRADA_DEBOUNCE_EN
    sh.push_back(s);
    if (sh.size() >= DC) begin
      bit all_differ = 1'b1;
      for (int i = 1; i <= DC; i++)
        if (sh[sh.size()-i] == db_cur) all_differ = 1'b0;
      if (all_differ) db_new = !db_cur;
    end
`else
    db_new = s;
`endif
    dbh.push_back(db_new);
    bh.push_back(boton);
  endfunction

  task automatic compare_model(input string tag);
    check({tag, " valid"}, 16'(valid), 16'(m_valid));
    check({tag, " _A"},    16'(q_a),   16'(m_a));
    check({tag, " _B"},    16'(q_b),   16'(m_b));
    check({tag, " ovr"},   16'(ovr),   16'(m_ovr));
  endtask

  // Drive inputs away from the edge, clock once, then compare 1 time unit later.
  task automatic tick(input logic bt, input logic rd, input logic [W-1:0] av, input logic [W-1:0] bv);
    boton = bt; ready = rd; a = av; b = bv;
    @(posedge clk);
    model_step();
    #1;
    compare_model("model");
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  typedef struct {
    logic         bt, rd;
    logic [W-1:0] av, bv;
    int           cycles;
    logic         e_valid;
    logic [W-1:0] e_a, e_b;
    logic         e_ovr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int   captures;
    logic prev_valid;
    int   run;
    logic rb;

    //            bt    rd    A        B        cycles  valid A        B        ovr
    tbl[0]  = '{1'b1, 1'b0, 4'b1011, 4'b0110, LAT,    1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'b1011, 4'b0110, 1,      1'b1, 4'b1011, 4'b0110, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'b1011, 4'b0110, 20,     1'b1, 4'b1011, 4'b0110, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b0001, 4'b0110, LAT+2,  1'b1, 4'b1011, 4'b0110, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'b0001, 4'b0110, LAT,    1'b1, 4'b1011, 4'b0110, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 4'b0001, 4'b0110, 1,      1'b1, 4'b1011, 4'b0110, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 4'b0001, 4'b0110, 1,      1'b1, 4'b1011, 4'b0110, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b0001, 4'b0110, LAT+2,  1'b1, 4'b1011, 4'b0110, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'b0011, 4'b0101, LAT,    1'b1, 4'b1011, 4'b0110, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 4'b0011, 4'b0101, 1,      1'b1, 4'b0011, 4'b0101, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'b0011, 4'b0101, 1,      1'b0, 4'b0011, 4'b0101, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 4'b0011, 4'b0101, 3,      1'b0, 4'b0011, 4'b0101, 1'b0};

    // Reset state.
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    check("reset valid", 16'(valid), 16'd0);
    check("reset _A",    16'(q_a),   16'd0);
    check("reset _B",    16'(q_b),   16'd0);
    check("reset ovr",   16'(ovr),   16'd0);

    // Directed table: capture, hold, dropped press, consume-and-recapture, consume.
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < tbl[i].cycles; c++)
        tick(tbl[i].bt, tbl[i].rd, tbl[i].av, tbl[i].bv);
      check($sformatf("tbl[%0d] valid", i), 16'(valid), 16'(tbl[i].e_valid));
      check($sformatf("tbl[%0d] _A", i),    16'(q_a),   16'(tbl[i].e_a));
      check($sformatf("tbl[%0d] _B", i),    16'(q_b),   16'(tbl[i].e_b));
      check($sformatf("tbl[%0d] ovr", i),   16'(ovr),   16'(tbl[i].e_ovr));
    end

    // Bounce: high 3, low 1, then held high.
    do_reset();
    captures = 0;
    prev_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick(j != 3, 1'b0, 4'b1011, 4'b0110);
      if (valid && !prev_valid) captures++;
      prev_valid = valid;
    end
    for (int j = 0; j <= LAT + 10; j++) begin
      tick(1'b1, 1'b0, 4'b1011, 4'b0110);
      if (valid && !prev_valid) captures++;
      prev_valid = valid;
`ifdef SS_ENTRADA_DEBOUNCE_EN
      if (j == LAT - 1) check("bounce early valid", 16'(valid), 16'd0);
      if (j == LAT)     check("bounce late valid",  16'(valid), 16'd1);
`endif
    end
`ifdef SS_ENTRADA_DEBOUNCE_EN
    check("bounce captures", 16'(captures), 16'd1);
`endif

    // Asynchronous reset between edges while in HOLD.
    check("hold before rst", 16'(valid), 16'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst valid", 16'(valid), 16'd0);
    check("async rst _A",    16'(q_a),   16'd0);
    check("async rst _B",    16'(q_b),   16'd0);
    check("async rst ovr",   16'(ovr),   16'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Reset mid-debounce with the button still held: full latency afterwards.
    for (int j = 0; j < 3; j++) tick(1'b1, 1'b0, 4'b0111, 4'b1001);
    do_reset();
    for (int j = 0; j <= LAT; j++) begin
      tick(1'b1, 1'b0, 4'b1100, 4'b0011);
      if (j == LAT - 1) check("post-rst early valid", 16'(valid), 16'd0);
      if (j == LAT)     check("post-rst late valid",  16'(valid), 16'd1);
    end
    check("post-rst _A", 16'(q_a), 16'(4'b1100));

    // Randomized run against the model.
    do_reset();
    run = 0;
    rb  = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      if (run == 0) begin
        rb  = 1'($urandom_range(1, 0));
        run = $urandom_range(10, 1);
      end
      run--;
      tick(rb, $urandom_range(3, 0) == 0, W'($urandom), W'($urandom));
    end

    // Wide instance: full-width capture, then consume.
    boton = 1'b0; ready = 1'b0;
    do_reset();
    a8 = 8'hA5; b8 = 8'h3C; boton8 = 1'b1;
    for (int j = 0; j <= LAT; j++) begin
      @(posedge clk); #1;
      if (j == LAT - 1) check("w8 early valid", 16'(valid8), 16'd0);
    end
    check("w8 valid", 16'(valid8), 16'd1);
    check("w8 _A",    16'(q_a8),   16'h00A5);
    check("w8 _B",    16'(q_b8),   16'h003C);
    check("w8 ovr",   16'(ovr8),   16'd0);
    ready8 = 1'b1;
    @(posedge clk); #1;
    check("w8 consumed valid", 16'(valid8), 16'd0);
    check("w8 retained _A",    16'(q_a8),   16'h00A5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
